// File: rtl/watch_time_counter.sv
// watch_time_counter: 100 Hz time base with h:m:s:cs counters and per-field edits; HOUR_12_EN selects 12-hour mode with PM flag.
module watch_time_counter #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_edit,
  input  logic [1:0] i_edit_msec,
  input  logic [1:0] i_edit_sec,
  input  logic [1:0] i_edit_min,
  input  logic [1:0] i_edit_hour,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic       o_tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
`ifdef HOUR_12_EN
  localparam logic [6:0] H_LO = 7'd1;
  localparam logic [6:0] H_HI = 7'd12;
`else
  localparam logic [6:0] H_LO = 7'd0;
  localparam logic [6:0] H_HI = 7'd23;
`endif
  logic [PW-1:0] pre;
  logic pend, tick_raw, adv, any_edit, apply, c_ms, c_s, c_m;
  logic [6:0] msec_n;
  logic [5:0] sec_n, min_n;
  logic [4:0] hour_n, hour_adv;
  logic pm_n;
  // Both +1 (01) and -1 (11) have bit 0 set; none (00) and reserved (10) do not.
  function automatic logic [6:0] edit_val(input logic [6:0] v, input logic [1:0] c,
                                          input logic [6:0] lo, input logic [6:0] hi);
    return (c == 2'b01) ? ((v == hi) ? lo : v + 7'd1) :
           (c == 2'b11) ? ((v == lo) ? hi : v - 7'd1) : v;
  endfunction
  always_comb begin
    tick_raw = !i_edit && (pre == PW'(TICK_DIV - 1));
    adv      = !i_edit && (tick_raw || pend);
    any_edit = i_edit_msec[0] | i_edit_sec[0] | i_edit_min[0] | i_edit_hour[0];
    apply    = adv && !any_edit;
    c_ms     = o_msec == 7'd99;
    c_s      = c_ms && (o_sec == 6'd59);
    c_m      = c_s && (o_min == 6'd59);
`ifdef HOUR_12_EN
    hour_adv = (o_hour == 5'd12) ? 5'd1 : o_hour + 5'd1;
    pm_n     = (apply && c_m && o_hour == 5'd11) ? ~o_pm : o_pm;
`else
    hour_adv = (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
    pm_n     = 1'b0;
`endif
    msec_n = any_edit ? edit_val(o_msec, i_edit_msec, 7'd0, 7'd99) :
             apply ? (c_ms ? 7'd0 : o_msec + 7'd1) : o_msec;
    sec_n  = any_edit ? 6'(edit_val({1'b0, o_sec}, i_edit_sec, 7'd0, 7'd59)) :
             (apply && c_ms) ? ((o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1) : o_sec;
    min_n  = any_edit ? 6'(edit_val({1'b0, o_min}, i_edit_min, 7'd0, 7'd59)) :
             (apply && c_s) ? ((o_min == 6'd59) ? 6'd0 : o_min + 6'd1) : o_min;
    hour_n = any_edit ? 5'(edit_val({2'b00, o_hour}, i_edit_hour, H_LO, H_HI)) :
             (apply && c_m) ? hour_adv : o_hour;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      pend   <= 1'b0;
      o_msec <= 7'd0;
      o_sec  <= 6'd0;
      o_min  <= 6'd0;
      o_hour <= 5'(INIT_HOUR);
      o_pm   <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      pre    <= i_edit ? pre : (tick_raw ? '0 : pre + PW'(1));
      pend   <= (adv && any_edit) || (pend && !apply);
      o_msec <= msec_n;
      o_sec  <= sec_n;
      o_min  <= min_n;
      o_hour <= hour_n;
      o_pm   <= pm_n;
      o_tick <= apply;
    end
  end
endmodule

// File: doc/watch_time_counter.md
Name: watch_time_counter

Overview:
- Timekeeping datapath for watch mode, directly downstream of the mode/edit control unit.
- Generates a 100 Hz centisecond time base from the system clock and keeps hour:min:sec:centisec counters.
- Applies per-field up/down edit pulses from the control unit (o_edit_msec/sec/min/hour).
- Feeds the display mux / FND driver.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per centisecond tick (100 MHz / 100 Hz); benches use small values such as 4.
- INIT_HOUR, 12, hour value loaded on reset. Range 0..23, or 1..12 under HOUR_12_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  reset
- i_edit  input  1  edit switch; 1 = time base paused
- i_edit_msec  input  2  centisecond edit code
- i_edit_sec  input  2  second edit code
- i_edit_min  input  2  minute edit code
- i_edit_hour  input  2  hour edit code
- o_msec  output  7  centiseconds, 0..99
- o_sec  output  6  seconds, 0..59
- o_min  output  6  minutes, 0..59
- o_hour  output  5  hours, 0..23
- o_pm  output  1  PM flag
- o_tick  output  1  one-cycle pulse, high in the cycle after a centisecond advance

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values (on the clk edge where reset=1):
  - o_msec=0, o_sec=0, o_min=0, o_hour=INIT_HOUR, o_pm=0, o_tick=0
  - prescaler=0, tick_pending=0
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick_raw=1 in the cycle it equals TICK_DIV-1.
  - While i_edit=1: prescaler holds its value, tick_raw=0, tick_pending holds.
- Edit codes:
  - 2'b01 = +1, 2'b11 = -1, 2'b00 = none, 2'b10 = reserved, ignored.
  - A code is applied on every cycle it is present; upstream guarantees single-cycle pulses.
  - Edits are accepted regardless of i_edit.
  - Each field wraps within its own range with no carry or borrow: msec 99<->0, sec/min 59<->0, hour 23<->0.
  - Multiple fields with nonzero codes in one cycle: all applied independently.
  - Latency: code present in cycle N -> new value visible in cycle N+1.
- Advance (adv = tick_raw | tick_pending):
  - Applied only in a cycle with no nonzero edit code (2'b10 counts as zero).
  - msec+1. At 99: msec->0 and carry to sec.
  - sec 59 -> 0, carry to min.
  - min 59 -> 0, carry to hour.
  - hour 23 -> 0.
- Collision:
  - adv coincides with any nonzero edit code: edit applied, advance deferred by setting tick_pending=1.
  - tick_pending cleared in the cycle the advance is applied.
  - No ticks are ever lost; at most one is pending, since TICK_DIV>=2 guarantees no second tick before it is drained.
- o_tick: registered; high for exactly one cycle following each applied advance, aligned with the updated counters.
- Reset mid-operation: pending tick discarded; prescaler restarts at 0.
- o_pm: constant 0 without HOUR_12_EN.

Optional Feature:
- Macro: HOUR_12_EN.
- Defined:
  - Hour range 1..12, counting 12,1,2,...,11.
  - Carry-driven 11->12 toggles o_pm; 12->1 does not toggle.
  - Edit wraps 12->1 (up) and 1->12 (down) without touching o_pm.
  - Reset: o_pm=0, hour=INIT_HOUR.
- Undefined: 24-hour behaviour as above; o_pm tied 0.

Test Plan:
- TICK_DIV=4, INIT_HOUR=23; set 23:59:59.98 via edit pulses; release -> after 2 ticks reads 00:00:00.00; o_tick pulses exactly twice, 4 cycles apart.
- min=59, pulse i_edit_min=2'b01 -> min=0 next cycle, hour unchanged. hour=0, pulse i_edit_hour=2'b11 -> hour=23.
- Drive i_edit_sec=2'b01 in the exact tick_raw cycle at sec=5, msec=10:
  - cycle N+1: sec=6, msec=10
  - cycle N+2: msec=11 with o_tick=1
- i_edit=1 for 20 cycles (TICK_DIV=4) -> counters and o_tick static; on release, next tick arrives after the remaining prescaler count.
- Assert reset at 07:33:12.45 with a tick pending -> next cycle 12:00:00.00, o_tick=0, and the first tick arrives TICK_DIV cycles later.
- i_edit_msec=2'b10 applied -> no change to msec. With HOUR_12_EN: 11:59:59.99 + tick -> 12:00:00.00 with o_pm 0->1.
